mouse_pos_ctrl: RTL

- Sequences the synchronized mouse-position datapath: takes the two-stage-synchronized xpos/ypos plus the synchronized left button.
- Rejects torn multi-bit samples with a stability filter, then clamps to screen bounds.
- Publishes a frame-coherent cursor position on each frame start.
- Issues shot requests (click position snapshot) to the game logic with a req/ack handshake.

---
 rtl/mouse_pos_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mouse_pos_ctrl.sv
// Mouse position sequencer: stability filter, screen clamp,
// frame-coherent cursor publish and shot req/ack handshake.
module mouse_pos_ctrl #(
  parameter int STABLE_CYCLES = 4,
  parameter int X_MAX         = 1023,
  parameter int Y_MAX         = 767
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] xpos_bf1,
  input  logic [11:0] ypos_bf1,
  input  logic        left_bf1,
  input  logic        frame_start,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic        pos_valid,
  output logic        shot_req,
  output logic [11:0] shot_x,
  output logic [11:0] shot_y,
  input  logic        shot_ack,
  output logic        shot_overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE_CYCLES - 1);
  localparam logic [11:0] XM = 12'(X_MAX);
  localparam logic [11:0] YM = 12'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_t;

  state_t        state;
  logic [23:0]   s;
  logic [CW-1:0] cnt;
  logic [23:0]   cand;
  logic          cand_valid;
  logic          prev;

  logic [23:0] cur;
  logic [11:0] x_c;
  logic [11:0] y_c;
  logic        same;
  logic        rise;

  assign cur  = {xpos_bf1, ypos_bf1};
  assign same = (cur == s);
  assign x_c  = (xpos_bf1 > XM) ? XM : xpos_bf1;
  assign y_c  = (ypos_bf1 > YM) ? YM : ypos_bf1;
  assign rise = left_bf1 & ~prev;

  // cnt counts edges the sample has matched; load on the STABLE_CYCLES-th
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s          <= '0;
      cnt        <= '0;
      cand       <= '0;
      cand_valid <= 1'b0;
    end else begin
      s <= cur;
      if (!same)
        cnt <= '0;
      else if (cnt != CNT_SAT)
        cnt <= cnt + CW'(1);
      if (same && cnt >= CNT_LOAD) begin
        cand       <= {x_c, y_c};
        cand_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpos_out  <= '0;
      ypos_out  <= '0;
      pos_valid <= 1'b0;
    end else if (frame_start && cand_valid) begin
      xpos_out  <= cand[23:12];
      ypos_out  <= cand[11:0];
      pos_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prev         <= 1'b0;
      shot_req     <= 1'b0;
      shot_x       <= '0;
      shot_y       <= '0;
      shot_overrun <= 1'b0;
    end else begin
      prev <= left_bf1;
      unique case (state)
        IDLE: begin
          if (rise && pos_valid) begin
            shot_x   <= xpos_out;
            shot_y   <= ypos_out;
            shot_req <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (rise)
            shot_overrun <= 1'b1;
          if (shot_ack) begin
            shot_req <= 1'b0;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          if (!left_bf1)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
